// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream adapter: default word
// width, buffer occupancy encoding and the beat-counter width helper.
package fifo_pkg;

  localparam int DATAWIDTH = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  // Beat counter width: clog2(pkt_len), never narrower than one bit.
  function automatic int beat_w(input int pkt_len);
    return (pkt_len <= 2) ? 1 : $clog2(pkt_len);
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-slot output buffer between the FIFO read port and a valid/ready
// consumer. The pop strobe depends only on the registered occupancy and the
// FIFO empty flag, so the consumer's ready never reaches the FIFO
// combinationally.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int datawidth = DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [datawidth-1:0] din,
  input  logic                 src_empty,
  output logic                 pop,
  output logic [datawidth-1:0] dout,
  output logic                 valid,
  input  logic                 ready,
  output logic                 accept
);

  occ_t                 occ;
  logic [datawidth-1:0] h;
  logic [datawidth-1:0] t;

  assign pop    = !rst && !src_empty && (occ != TWO);
  assign valid  = (occ != EMPTY);
  assign accept = valid && ready;
  assign dout   = h;

  // Occupancy state machine: capture popped words into head or tail, shift
  // tail into head when the head is consumed with both slots full.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= EMPTY;
      h   <= '0;
      t   <= '0;
    end else begin
      unique case (occ)
        EMPTY: begin
          if (pop) begin
            h   <= din;
            occ <= ONE;
          end
        end
        ONE: begin
          if (pop && accept) begin
            h <= din;
          end else if (pop) begin
            t   <= din;
            occ <= TWO;
          end else if (accept) begin
            occ <= EMPTY;
          end
        end
        TWO: begin
          if (accept) begin
            h   <= t;
            occ <= ONE;
          end
        end
        default: occ <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter downstream of the async FIFO: pops words into a 2-slot
// buffer and presents them as a framed valid/ready stream with out_last on
// every PKT_LEN-th word and a wrapping completed-packet count.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int datawidth = DATAWIDTH,
  parameter int PKT_LEN   = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [datawidth-1:0] rdata,
  input  logic                 rempty,
  output logic                 rinc,
  output logic [datawidth-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [CNT_W-1:0]     pkt_cnt
);

  localparam int                BEAT_W    = beat_w(PKT_LEN);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

  logic [BEAT_W-1:0] beat;
  logic              accept;

  skid_buf2 #(
    .datawidth(datawidth)
  ) u_buf (
    .clk      (rclk),
    .rst      (rrst),
    .din      (rdata),
    .src_empty(rempty),
    .pop      (rinc),
    .dout     (out_data),
    .valid    (out_valid),
    .ready    (out_ready),
    .accept   (accept)
  );

  assign out_last = out_valid && (beat == BEAT_LAST);

  // Framing: count beats within a packet, close the packet on the last beat.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      beat    <= '0;
      pkt_cnt <= '0;
    end else if (accept) begin
      if (out_last) begin
        beat    <= '0;
        pkt_cnt <= pkt_cnt + 1'b1;
      end else begin
        beat <= beat + 1'b1;
      end
    end
  end

endmodule
